// File: rtl/serial_adder_pkg.sv
// Shared state encoding and default counter width for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam int CNT_W_DEF = 5;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/request and result bundle; the requester drives the master side.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, op_a, op_b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, op_a, op_b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder; purely combinational, count is the carry-out.
module full_adder (
  input  logic in_1,
  input  logic in_2,
  input  logic cin,
  output logic sum,
  output logic count
);

  assign sum   = in_1 ^ in_2 ^ cin;
  assign count = (in_1 & in_2) | (cin & (in_1 ^ in_2));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit pair per cycle, result + done pulse WIDTH cycles after start.
// No backpressure; start is only honoured in IDLE and is dropped while busy.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic            sys_clk,
  input logic            sys_rst_n,
  serial_adder_if.slave  bus
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh, a_sh_d;
  logic [WIDTH-1:0]   b_sh, b_sh_d;
  logic [WIDTH-1:0]   sum_sh, sum_sh_d;
  logic               carry_reg, carry_d;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               done_q, done_d;
  logic               fa_sum;
  logic               fa_count;

  full_adder full_adder_inst (
    .in_1  (a_sh[0]),
    .in_2  (b_sh[0]),
    .cin   (carry_reg),
    .sum   (fa_sum),
    .count (fa_count)
  );

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh;
    b_sh_d    = b_sh;
    sum_sh_d  = sum_sh;
    carry_d   = carry_reg;
    bit_cnt_d = bit_cnt;
    sum_d     = sum_q;
    cout_d    = cout_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d    = bus.op_a;
          b_sh_d    = bus.op_b;
          carry_d   = bus.cin;
          bit_cnt_d = '0;
          sum_sh_d  = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        a_sh_d    = {1'b0, a_sh[WIDTH-1:1]};
        b_sh_d    = {1'b0, b_sh[WIDTH-1:1]};
        sum_sh_d  = {fa_sum, sum_sh[WIDTH-1:1]};
        carry_d   = fa_count;
        bit_cnt_d = bit_cnt + CNT_W'(1);
        // Last bit pair is consumed on the same edge that publishes the result.
        if (bit_cnt == CNT_W'(WIDTH - 1)) begin
          sum_d   = {fa_sum, sum_sh[WIDTH-1:1]};
          cout_d  = fa_count;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry_reg <= 1'b0;
      bit_cnt   <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh      <= a_sh_d;
      b_sh      <= b_sh_d;
      sum_sh    <= sum_sh_d;
      carry_reg <= carry_d;
      bit_cnt   <= bit_cnt_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q == CALC);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed checks of serial_adder against plain-arithmetic expectations.
module tb_serial_adder;

  localparam int W = 8;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  always #5 sys_clk = ~sys_clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;
  logic [W:0] prev_res;

  always @(negedge sys_clk) if (bus.done === 1'b1) done_seen++;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a start at the current negedge; returns at the negedge after the start edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
    @(negedge sys_clk);
    bus.start = 1'b0;
    bus.op_a  = W'($urandom);
    bus.op_b  = W'($urandom);
    bus.cin   = 1'($urandom);
  endtask

  // Counts edges from the start edge until done, watching busy and result stability.
  task automatic wait_done(input bit glitch, output int edges, output int busy_cnt, output bit held);
    edges    = 0;
    busy_cnt = 0;
    held     = 1'b1;
    while (bus.done !== 1'b1 && edges < 20) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if ({bus.cout, bus.sum} !== prev_res) held = 1'b0;
      if (glitch && edges >= 2 && edges <= 4) begin
        bus.start = 1'b1;
        bus.op_a  = 8'h11;
        bus.op_b  = 8'h22;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge sys_clk);
      edges++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic c, input int edges, input int busy_cnt, input bit held);
    logic [W:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    check_val({tag, ".latency"}, 64'(edges), 64'(W));
    check_val({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(W));
    check_val({tag, ".held"}, 64'(held), 64'd1);
    check_val({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
    check_val({tag, ".result"}, 64'({bus.cout, bus.sum}), 64'(exp));
    prev_res = exp;
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input bit glitch);
    int  edges;
    int  busy_cnt;
    bit  held;
    issue(a, b, c);
    wait_done(glitch, edges, busy_cnt, held);
    check_result(tag, a, b, c, edges, busy_cnt, held);
    @(negedge sys_clk);
    check_val({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int edges;
    int busy_cnt;
    bit held;
    int done_base;
    logic [W-1:0] ra, rb;
    logic rc;

    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.cin   = 1'b0;
    sys_rst_n = 1'b0;
    prev_res  = '0;
    #12 sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check_val("rst.busy", 64'(bus.busy), 64'd0);
    check_val("rst.done", 64'(bus.done), 64'd0);
    check_val("rst.sum",  64'(bus.sum),  64'd0);
    check_val("rst.cout", 64'(bus.cout), 64'd0);

    do_op("basic", 8'h3C, 8'h5A, 1'b0, 1'b0);
    do_op("wrap",  8'hFF, 8'h01, 1'b0, 1'b0);
    do_op("max",   8'hFF, 8'hFF, 1'b1, 1'b0);

    done_base = done_seen;
    do_op("ignore", 8'h01, 8'h01, 1'b0, 1'b1);
    repeat (12) @(negedge sys_clk);
    check_val("ignore.busy_after", 64'(bus.busy), 64'd0);
    check_val("ignore.done_count", 64'(done_seen - done_base), 64'd1);

    // Back-to-back: start is held in the done cycle of the first operation.
    issue(8'h55, 8'h0F, 1'b0);
    wait_done(1'b0, edges, busy_cnt, held);
    check_result("b2b_first", 8'h55, 8'h0F, 1'b0, edges, busy_cnt, held);
    issue(8'h10, 8'h20, 1'b0);
    wait_done(1'b0, edges, busy_cnt, held);
    check_val("b2b.gap", 64'(edges + 1), 64'(W + 1));
    check_result("b2b_second", 8'h10, 8'h20, 1'b0, edges, busy_cnt, held);
    @(negedge sys_clk);

    issue(8'h13, 8'h25, 1'b1);
    repeat (4) @(negedge sys_clk);
    check_val("midrst.busy_before", 64'(bus.busy), 64'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    check_val("midrst.busy", 64'(bus.busy), 64'd0);
    check_val("midrst.done", 64'(bus.done), 64'd0);
    check_val("midrst.sum",  64'(bus.sum),  64'd0);
    check_val("midrst.cout", 64'(bus.cout), 64'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    prev_res  = '0;
    done_base = done_seen;
    repeat (12) @(negedge sys_clk);
    check_val("midrst.no_done", 64'(done_seen - done_base), 64'd0);
    do_op("after_rst", 8'h7F, 8'h01, 1'b0, 1'b0);

    done_base = done_seen;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      do_op("rand", ra, rb, rc, ($urandom_range(0, 3) == 0));
    end
    check_val("rand.done_count", 64'(done_seen - done_base), 64'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder placed directly upstream of the existing full_adder; the full_adder is its only arithmetic element.
- On start, latches two operands and a carry-in, then feeds one bit pair per clock, LSB first, into a full_adder instance.
- Feeds the full_adder carry out back through a carry register.
- Collects sum bits in a shift register and presents the registered WIDTH-bit sum and carry-out with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CNT_W, 5, bit counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- sys_clk  input  1  system clock; all state updates on rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op_a  input  WIDTH  operand A, sampled with start.
- op_b  input  WIDTH  operand B, sampled with start.
- cin  input  1  carry-in, sampled with start.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse, result valid.
- sum  output  WIDTH  registered result.
- cout  output  1  registered carry-out.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sys_rst_n is asynchronous, active-low.
- Reset values: state=IDLE; busy=0, done=0, sum=0, cout=0; all shift registers, carry_reg and bit_cnt = 0.
- State IDLE:
  - start=1 at a rising edge: a_sh<=op_a, b_sh<=op_b, carry_reg<=cin, bit_cnt<=0, sum_sh<=0, state<=CALC.
  - start=0: hold.
- State CALC, every edge:
  - full_adder inputs: in_1=a_sh[0], in_2=b_sh[0], cin=carry_reg.
  - a_sh and b_sh shift right by one, zero-fill.
  - sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]}.
  - carry_reg <= fa_count.
  - bit_cnt <= bit_cnt+1.
- End of CALC, when bit_cnt==WIDTH-1 on an edge:
  - The last bit is processed on that same edge.
  - sum <= {fa_sum, sum_sh[WIDTH-1:1]}, cout <= fa_count, done <= 1, state <= IDLE.
- done is high for exactly one cycle; it is cleared on the next edge.
- Latency: the start edge is edge 0, CALC occupies edges 1..WIDTH, and done/sum/cout update on edge WIDTH. busy is high from after edge 0 until after edge WIDTH, i.e. WIDTH cycles.
- sum and cout hold their value until the next operation completes. They do not change during CALC.
- start while busy: ignored; operands are not resampled.
- start during the done cycle: accepted, since state is IDLE. Back-to-back throughput is one result per WIDTH+1 cycles.
- Reset mid-operation: asynchronous return to reset values. The partial result is discarded and no done pulse is produced.
- Arithmetic: {cout,sum} == op_a + op_b + cin, modulo 2**(WIDTH+1). No overflow flag.
- Inputs op_a, op_b and cin may change freely after the start edge.

Decomposition:
- Shared package holds the state encodings (IDLE=1'b0, CALC=1'b1) and the CNT_W default.
- The natural sub-module is the existing full_adder, instantiated once as full_adder_inst, with ports in_1, in_2, cin, sum, count.
- No other sub-modules.

Test Plan:
- WIDTH=8: op_a=8'h3C, op_b=8'h5A, cin=0, start pulse -> busy for 8 cycles; done pulse on the 8th edge after start; sum=8'h96, cout=0.
- op_a=8'hFF, op_b=8'h01, cin=0 -> sum=8'h00, cout=1; then op_a=8'hFF, op_b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- start re-asserted with op_a=8'h11, op_b=8'h22 during busy of a 8'h01+8'h01 operation -> ignored; result sum=8'h02, cout=0, a single done pulse.
- Back-to-back: start held in the done cycle with 8'h10+8'h20 -> second done exactly 9 cycles after the first; sum=8'h30; the first result holds until then.
- Reset asserted at cycle 4 of CALC -> busy=0, done=0, sum=0, cout=0 immediately (asynchronous); a subsequent 8'h7F+8'h01 yields 8'h80, cout=0.
- Randomised 1000 operations checked against op_a+op_b+cin, with done asserted exactly once per accepted start.
